// File: rtl/decode_stage.sv
// Arya decode stage: cracks one instruction into datapath controls and
// holds it in a one-entry output register with load-use bubbling.
module decode_stage #(
  parameter int DATAPATH_WIDTH     = 64,
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int INST_ADDR_WIDTH    = 9,
  parameter bit SIGN_EXT           = 1'b0,
  parameter bit ZERO_REG_HAZARD    = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   inst_in,
  input  logic                          inst_valid,
  output logic                          inst_ready,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [REGFILE_ADDR_WIDTH-1:0] R1_addr_out,
  output logic [REGFILE_ADDR_WIDTH-1:0] R2_addr_out,
  output logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_out,
  output logic [DATAPATH_WIDTH-1:0]     imm_out,
  output logic [INST_ADDR_WIDTH-1:0]    branch_offset,
  output logic [3:0]                    alu_ctrl_out,
  output logic                          WR_en_out,
  output logic                          beq_out,
  output logic                          bneq_out,
  output logic                          imm_sel_out,
  output logic                          mem_write_out,
  output logic                          mem_reg_sel,
  output logic [31:0]                   stall_count
);

  localparam int DW = DATAPATH_WIDTH;
  localparam int RA = REGFILE_ADDR_WIDTH;
  localparam int IA = INST_ADDR_WIDTH;

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic [RA-1:0] r1;
    logic [RA-1:0] r2;
    logic [RA-1:0] wr;
    logic [DW-1:0] imm;
    logic [IA-1:0] boff;
    logic [3:0]    alu;
    logic [5:0]    ctl;
  } dec_t;

  state_t      state_q, state_d;
  dec_t        dec_q, dec_d, dec_n;
  logic [31:0] stall_q, stall_d;

  logic [5:0] op;
  logic       held_ld;
  logic       use_r2;
  logic       dst_ok;
  logic       match;
  logic       hazard;
  logic       accept;

  always_comb begin
    op          = inst_in[31:26];
    dec_n       = '0;
    dec_n.r1    = inst_in[25:21];
    dec_n.r2    = inst_in[20:16];
    dec_n.wr    = inst_in[15:11];
    dec_n.boff  = inst_in[IA-1:0];
    dec_n.ctl   = op;
    if (SIGN_EXT) dec_n.imm = DW'($signed(inst_in[15:0]));
    else          dec_n.imm = DW'(inst_in[15:0]);
    priority case (1'b1)
      op[2]:         dec_n.alu = 4'd1;
      op[4] | op[3]: dec_n.alu = 4'd2;
      default:       dec_n.alu = inst_in[3:0];
    endcase
  end

  // Stores read R2 as write data even though they use the immediate.
  always_comb begin
    held_ld = (state_q == FULL) & dec_q.ctl[5] & dec_q.ctl[0];
    use_r2  = ~op[2] | op[1];
    dst_ok  = ZERO_REG_HAZARD || (dec_q.wr != '0);
    match   = (dec_q.wr == dec_n.r1) | (use_r2 & (dec_q.wr == dec_n.r2));
    hazard  = held_ld & inst_valid & dst_ok & match;
    inst_ready = ~flush & ~hazard & ((state_q == EMPTY) | out_ready);
    accept  = inst_valid & inst_ready;
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    stall_d = stall_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (accept) begin
      state_d = FULL;
      dec_d   = dec_n;
    end else if (out_ready) begin
      state_d = EMPTY;
    end
    if (hazard && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      dec_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      stall_q <= stall_d;
    end
  end

  assign out_valid     = (state_q == FULL);
  assign R1_addr_out   = dec_q.r1;
  assign R2_addr_out   = dec_q.r2;
  assign WR_addr_out   = dec_q.wr;
  assign imm_out       = dec_q.imm;
  assign branch_offset = dec_q.boff;
  assign alu_ctrl_out  = dec_q.alu;
  assign WR_en_out     = dec_q.ctl[5];
  assign beq_out       = dec_q.ctl[4];
  assign bneq_out      = dec_q.ctl[3];
  assign imm_sel_out   = dec_q.ctl[2];
  assign mem_write_out = dec_q.ctl[1];
  assign mem_reg_sel   = dec_q.ctl[0];
  assign stall_count   = stall_q;

endmodule
